// File: rtl/tx_stats_pkg.sv
// Shared definitions for the TX statistics record path: record layout,
// flag bit positions and the packet-tracking FSM encoding.
package tx_stats_pkg;

  localparam int DSIZE = 72;

  localparam int PORT_LSB = 68;
  localparam int LEN_LSB  = 52;
  localparam int TS_LSB   = 20;
  localparam int SEQ_LSB  = 4;

  localparam int FLAGS_W   = 4;
  localparam int FLAG_SAT  = 0;
  localparam int FLAG_ERR  = 1;
  localparam int FLAG_DROP = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/tx_stats_pending_q.sv
// Two-entry holding queue between record completion and the async FIFO.
// The head sits in its own register so the FIFO write data is glitch-free.
module tx_stats_pending_q #(
  parameter int W = 72
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] head_reg;
  logic [W-1:0] tail_reg;
  logic [1:0]   count_reg;
  logic         pop_ok;
  logic         push_ok;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign head    = head_reg;
  assign pop_ok  = pop & ~empty;
  // A pop on the same edge frees a slot, so a full queue can still take a push.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= din;
          else                   tail_reg <= din;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            head_reg <= din;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tx_stats_record_writer.sv
// Measures each TX packet (port, length, start timestamp, sequence) and pushes
// a 72-bit record into the async stats FIFO without ever stalling the datapath.
module tx_stats_record_writer #(
  parameter int DSIZE   = 72,
  parameter int PORT_W  = 4,
  parameter int LEN_W   = 16,
  parameter int TS_W    = 32,
  parameter int SEQ_W   = 16,
  parameter int DROP_W  = 16,
  parameter int BYTES_W = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               stats_en,
  input  logic               pkt_valid,
  input  logic               pkt_sop,
  input  logic               pkt_eop,
  input  logic [PORT_W-1:0]  pkt_port,
  input  logic [BYTES_W-1:0] pkt_bytes,
  output logic [DSIZE-1:0]   fifo_wdata,
  output logic               fifo_winc,
  input  logic               fifo_wfull,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               busy
);

  import tx_stats_pkg::*;

  state_t              state_reg, state_next;
  logic [TS_W-1:0]     ts_reg;
  logic [SEQ_W-1:0]    seq_reg;
  logic [PORT_W-1:0]   port_reg, port_next;
  logic [TS_W-1:0]     ts_lat_reg, ts_lat_next;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic                sat_reg, sat_next;
  logic                skip_reg, skip_next;
  logic                err_reg;
  logic                drop_pend_reg;
  logic [DROP_W-1:0]   drop_cnt_reg;

  logic [LEN_W:0]      len_sum;
  logic [LEN_W-1:0]    acc_len;
  logic                acc_sat;
  logic                complete;
  logic                err_hit;
  logic                err_now;
  logic [PORT_W-1:0]   rec_port;
  logic [TS_W-1:0]     rec_ts;
  logic [LEN_W-1:0]    rec_len;
  logic                rec_sat;
  logic [FLAGS_W-1:0]  rec_flags;
  logic [DSIZE-1:0]    rec_data;

  logic                q_push, q_pop, q_full, q_empty;
  logic                accept, dropped;

  assign len_sum = {1'b0, len_reg} + (LEN_W+1)'(pkt_bytes);
  assign acc_len = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
  assign acc_sat = sat_reg | len_sum[LEN_W];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and packet-datapath decisions for the current word.
  always_comb begin
    state_next  = state_reg;
    port_next   = port_reg;
    ts_lat_next = ts_lat_reg;
    len_next    = len_reg;
    sat_next    = sat_reg;
    skip_next   = skip_reg;
    err_hit     = 1'b0;
    complete    = 1'b0;
    rec_port    = port_reg;
    rec_ts      = ts_lat_reg;
    rec_len     = acc_len;
    rec_sat     = acc_sat;
    if (pkt_valid) begin
      if (pkt_sop) begin
        if (state_reg == ST_ACCUM) err_hit = 1'b1;
        if (stats_en) begin
          port_next   = pkt_port;
          ts_lat_next = ts_reg;
          len_next    = LEN_W'(pkt_bytes);
          sat_next    = 1'b0;
          skip_next   = 1'b0;
          rec_port    = pkt_port;
          rec_ts      = ts_reg;
          rec_len     = LEN_W'(pkt_bytes);
          rec_sat     = 1'b0;
          complete    = pkt_eop;
          state_next  = pkt_eop ? ST_IDLE : ST_ACCUM;
        end else begin
          // Disabled packet: swallow everything up to and including its eop.
          state_next = ST_IDLE;
          skip_next  = ~pkt_eop;
        end
      end else if (state_reg == ST_ACCUM) begin
        len_next = acc_len;
        sat_next = acc_sat;
        if (pkt_eop) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end else if (pkt_eop) begin
        if (skip_reg) skip_next = 1'b0;
        else          err_hit   = 1'b1;
      end
    end
  end

  always_comb begin
    q_pop     = ~q_empty & ~fifo_wfull;
    fifo_winc = q_pop;
    busy      = (state_reg == ST_ACCUM) | ~q_empty;
  end

  assign err_now = err_reg | err_hit;
  assign accept  = ~q_full | q_pop;
  assign q_push  = complete & accept;
  assign dropped = complete & ~accept;

  always_comb begin
    rec_flags            = '0;
    rec_flags[FLAG_SAT]  = rec_sat;
    rec_flags[FLAG_ERR]  = err_now;
    rec_flags[FLAG_DROP] = drop_pend_reg;
    rec_data                        = '0;
    rec_data[PORT_LSB +: PORT_W]    = rec_port;
    rec_data[LEN_LSB  +: LEN_W]     = rec_len;
    rec_data[TS_LSB   +: TS_W]      = rec_ts;
    rec_data[SEQ_LSB  +: SEQ_W]     = seq_reg;
    rec_data[0        +: FLAGS_W]   = rec_flags;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ts_reg        <= '0;
      seq_reg       <= '0;
      port_reg      <= '0;
      ts_lat_reg    <= '0;
      len_reg       <= '0;
      sat_reg       <= 1'b0;
      skip_reg      <= 1'b0;
      err_reg       <= 1'b0;
      drop_pend_reg <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      ts_reg     <= ts_reg + TS_W'(1);
      port_reg   <= port_next;
      ts_lat_reg <= ts_lat_next;
      len_reg    <= len_next;
      sat_reg    <= sat_next;
      skip_reg   <= skip_next;
      // Sticky flags persist until they actually reach an enqueued record.
      err_reg       <= q_push ? 1'b0 : err_now;
      drop_pend_reg <= q_push ? 1'b0 : (drop_pend_reg | dropped);
      if (complete) seq_reg <= seq_reg + SEQ_W'(1);
      if (dropped && (drop_cnt_reg != {DROP_W{1'b1}}))
        drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_reg;

  tx_stats_pending_q #(
    .W (DSIZE)
  ) u_pending_q (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .push   (q_push),
    .pop    (q_pop),
    .din    (rec_data),
    .head   (fifo_wdata),
    .full   (q_full),
    .empty  (q_empty)
  );

endmodule

// File: tb/tb_tx_stats_record_writer.sv
// Directed plus randomized bench for tx_stats_record_writer, checked against a
// packet-level reference model with a queue of expected FIFO records.
module tb_tx_stats_record_writer;
  import tx_stats_pkg::*;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic        stats_en = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_sop = 1'b0;
  logic        pkt_eop = 1'b0;
  logic [3:0]  pkt_port = '0;
  logic [3:0]  pkt_bytes = '0;
  logic        fifo_wfull = 1'b0;
  logic [71:0] fifo_wdata;
  logic        fifo_winc;
  logic [15:0] drop_cnt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 wclk = ~wclk;

  tx_stats_record_writer dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .stats_en   (stats_en),
    .pkt_valid  (pkt_valid),
    .pkt_sop    (pkt_sop),
    .pkt_eop    (pkt_eop),
    .pkt_port   (pkt_port),
    .pkt_bytes  (pkt_bytes),
    .fifo_wdata (fifo_wdata),
    .fifo_winc  (fifo_winc),
    .fifo_wfull (fifo_wfull),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  // Reference model: whole-packet view with an unbounded byte total.
  logic [71:0] m_q[$];
  bit          m_open, m_skip, m_err, m_drop_pend;
  int          m_total;
  logic [3:0]  m_port;
  logic [31:0] m_ts, m_ts0;
  logic [15:0] m_seq, m_drop;

  task automatic model_reset();
    m_q.delete();
    m_open = 0; m_skip = 0; m_err = 0; m_drop_pend = 0;
    m_total = 0; m_port = '0; m_ts = '0; m_ts0 = '0; m_seq = '0; m_drop = '0;
  endtask

  function automatic logic [71:0] mk_rec(input logic [3:0] port, input int total,
                                         input logic [31:0] ts, input logic [15:0] seq,
                                         input bit drop, input bit err);
    logic [15:0] len;
    bit sat;
    sat = (total > 65535);
    len = sat ? 16'hFFFF : 16'(total);
    return {port, len, ts, seq, 1'b0, drop, err, sat};
  endfunction

  task automatic model_step();
    bit pop, complete;
    pop = (m_q.size() > 0) && !fifo_wfull;
    complete = 0;
    if (pkt_valid) begin
      if (pkt_sop) begin
        if (m_open) m_err = 1;
        if (stats_en) begin
          m_port = pkt_port; m_ts0 = m_ts; m_total = int'(pkt_bytes); m_skip = 0;
          m_open = !pkt_eop; complete = pkt_eop;
        end else begin
          m_open = 0; m_skip = !pkt_eop;
        end
      end else if (m_open) begin
        m_total += int'(pkt_bytes);
        if (pkt_eop) begin m_open = 0; complete = 1; end
      end else if (pkt_eop) begin
        if (m_skip) m_skip = 0;
        else        m_err = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (complete) begin
      if (m_q.size() < 2) begin
        m_q.push_back(mk_rec(m_port, m_total, m_ts0, m_seq, m_drop_pend, m_err));
        m_err = 0; m_drop_pend = 0;
      end else begin
        if (m_drop != 16'hFFFF) m_drop++;
        m_drop_pend = 1;
      end
      m_seq++;
    end
    m_ts++;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("winc", 72'(fifo_winc), 72'((m_q.size() > 0) && !fifo_wfull));
    if (m_q.size() > 0) chk("wdata", fifo_wdata, m_q[0]);
    chk("drop_cnt", 72'(drop_cnt), 72'(m_drop));
    chk("busy", 72'(busy), 72'(m_open || (m_q.size() > 0)));
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic cyc(input bit v, input bit s, input bit e, input logic [3:0] p,
                     input logic [3:0] b, input bit wf, input bit en);
    pkt_valid = v; pkt_sop = s; pkt_eop = e; pkt_port = p; pkt_bytes = b;
    fifo_wfull = wf; stats_en = en;
    #1;
    check_outputs();
    model_step();
    @(negedge wclk);
  endtask

  task automatic idle(input bit wf);
    cyc(0, 0, 0, 4'd0, 4'd0, wf, 1);
  endtask

  initial begin
    int guard;
    int nw;
    bit wf, en;
    model_reset();
    @(negedge wclk);
    @(negedge wclk);
    #1;
    chk("rst_winc", 72'(fifo_winc), 72'(0));
    chk("rst_wdata", fifo_wdata, 72'(0));
    chk("rst_drop", 72'(drop_cnt), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    @(negedge wclk);
    wrst_n = 1'b1;

    // 64-byte packet on port 3 starting at ts=10
    guard = 0;
    while (m_ts != 32'd10 && guard < 50) begin idle(0); guard++; end
    chk("ts_reach", 72'(m_ts), 72'(10));
    for (int i = 0; i < 8; i++) cyc(1, i == 0, i == 7, 4'd3, 4'd8, 0, 1);
    #1;
    chk("t1_winc", 72'(fifo_winc), 72'(1));
    chk("t1_rec", fifo_wdata, {4'd3, 16'd64, 32'd10, 16'd0, 4'd0});
    idle(0);

    // single-word packet, busy for exactly one cycle
    cyc(1, 1, 1, 4'd7, 4'd5, 0, 1);
    #1;
    chk("t2_busy", 72'(busy), 72'(1));
    chk("t2_len", 72'(fifo_wdata[LEN_LSB +: 16]), 72'(5));
    chk("t2_seq", 72'(fifo_wdata[SEQ_LSB +: 16]), 72'(1));
    idle(0);
    #1;
    chk("t2_busy_off", 72'(busy), 72'(0));

    // FIFO full: two records held, third dropped
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 4'd1, 4'd2, 1, 1);
    idle(1);
    #1;
    chk("t3_winc", 72'(fifo_winc), 72'(0));
    chk("t3_drop", 72'(drop_cnt), 72'(1));
    chk("t3_busy", 72'(busy), 72'(1));
    idle(0);
    idle(0);
    cyc(1, 1, 1, 4'd2, 4'd3, 0, 1);
    #1;
    chk("t3_seq_gap", 72'(fifo_wdata[SEQ_LSB +: 16]), 72'(5));
    chk("t3_dropflag", 72'(fifo_wdata[FLAG_DROP]), 72'(1));
    idle(0);

    // length saturation, then a clean packet
    for (int i = 0; i < 8200; i++) cyc(1, i == 0, i == 8199, 4'd5, 4'd8, 0, 1);
    #1;
    chk("t4_len", 72'(fifo_wdata[LEN_LSB +: 16]), 72'(16'hFFFF));
    chk("t4_sat", 72'(fifo_wdata[FLAG_SAT]), 72'(1));
    idle(0);
    cyc(1, 1, 0, 4'd5, 4'd8, 0, 1);
    cyc(1, 0, 1, 4'd5, 4'd8, 0, 1);
    #1;
    chk("t4_sat_clr", 72'(fifo_wdata[FLAG_SAT]), 72'(0));
    idle(0);

    // protocol errors and disabled packets
    cyc(1, 1, 0, 4'd6, 4'd8, 0, 1);
    cyc(1, 0, 0, 4'd6, 4'd8, 0, 1);
    cyc(1, 1, 1, 4'd6, 4'd4, 0, 1);
    #1;
    chk("t5_len", 72'(fifo_wdata[LEN_LSB +: 16]), 72'(4));
    chk("t5_err", 72'(fifo_wdata[FLAG_ERR]), 72'(1));
    idle(0);
    cyc(1, 0, 1, 4'd0, 4'd3, 0, 1);
    cyc(1, 1, 1, 4'd9, 4'd1, 0, 1);
    #1;
    chk("t5_stray", 72'(fifo_wdata[FLAG_ERR]), 72'(1));
    idle(0);
    cyc(1, 1, 0, 4'd4, 4'd8, 0, 0);
    cyc(1, 0, 1, 4'd4, 4'd8, 0, 0);
    #1;
    chk("t5_noen_busy", 72'(busy), 72'(0));
    cyc(1, 1, 1, 4'd4, 4'd2, 0, 1);
    #1;
    chk("t5_noen_err", 72'(fifo_wdata[FLAG_ERR]), 72'(0));
    idle(0);

    // reset while accumulating with two records pending
    cyc(1, 1, 1, 4'd8, 4'd1, 1, 1);
    cyc(1, 1, 1, 4'd8, 4'd1, 1, 1);
    cyc(1, 1, 0, 4'd8, 4'd8, 1, 1);
    pkt_valid = 0; pkt_sop = 0; pkt_eop = 0;
    #2;
    wrst_n = 1'b0;
    #1;
    chk("t6_winc", 72'(fifo_winc), 72'(0));
    chk("t6_drop", 72'(drop_cnt), 72'(0));
    chk("t6_busy", 72'(busy), 72'(0));
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
    cyc(1, 1, 1, 4'd2, 4'd6, 0, 1);
    #1;
    chk("t6_seq0", 72'(fifo_wdata[SEQ_LSB +: 16]), 72'(0));
    idle(0);

    // randomized well-formed packets with FIFO back-pressure
    for (int k = 0; k < 300; k++) begin
      nw = int'($urandom_range(1, 6));
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < nw; i++) begin
        wf = ($urandom_range(0, 3) == 0);
        cyc(1, i == 0, i == nw - 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 8)), wf, en);
        if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 1) == 1);
      end
    end

    // randomized raw control, including protocol violations
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 8)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0);
    for (int k = 0; k < 6; k++) idle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
